// File: rtl/npu_dispatch.sv
// npu_dispatch: in-order NPU command queue, per-channel start/busy/done FSMs,
// completion arbiter and PC stall. Optional watchdog: NPU_DISPATCH_WATCHDOG_EN.
module npu_dispatch #(
  parameter int XLEN           = 64,
  parameter int NUM_CH         = 2,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [CHW-1:0]         cmd_ch,
  input  logic [XLEN-1:0]        cmd_arg0,
  input  logic [XLEN-1:0]        cmd_arg1,
  input  logic                   cmd_sync,
  output logic [NUM_CH-1:0]      npu_start,
  output logic [NUM_CH*XLEN-1:0] npu_arg0,
  output logic [NUM_CH*XLEN-1:0] npu_arg1,
  input  logic [NUM_CH-1:0]      npu_done,
  output logic                   cpl_valid,
  output logic [CHW-1:0]         cpl_ch,
  output logic                   cpl_status,
  output logic                   stall_pc,
  output logic [NUM_CH-1:0]      busy
);

  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;

  typedef enum logic [1:0] {
    CH_IDLE, CH_START, CH_BUSY, CH_DONE
  } ch_st_e;

  ch_st_e st_q [NUM_CH];
  ch_st_e st_d [NUM_CH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic [CHW-1:0]  q_ch   [QUEUE_DEPTH];
  logic [XLEN-1:0] q_a0   [QUEUE_DEPTH];
  logic [XLEN-1:0] q_a1   [QUEUE_DEPTH];
  logic            q_sync [QUEUE_DEPTH];

  logic [NUM_CH-1:0][XLEN-1:0] a0_q;
  logic [NUM_CH-1:0][XLEN-1:0] a1_q;
  logic [NUM_CH-1:0]           ch_sync_q;
  logic [NUM_CH-1:0]           expire;
  logic                        sync_pend;

  logic           push;
  logic           pop;
  logic [CHW-1:0] head_ch;
  logic           rep_valid;
  logic [CHW-1:0] rep_ch;
  logic           sync_cpl;

  assign cmd_ready = (count != (PW+1)'(QUEUE_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head_ch   = q_ch[rd_ptr];
  assign pop       = (count != '0) && (st_q[head_ch] == CH_IDLE);

  // lowest-index channel in DONE gets the report slot
  always_comb begin
    rep_valid = 1'b0;
    rep_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (st_q[i] == CH_DONE) begin
        rep_valid = 1'b1;
        rep_ch    = CHW'(i);
      end
    end
  end

  assign sync_cpl   = rep_valid && ch_sync_q[rep_ch];
  assign cpl_valid  = rep_valid;
  assign cpl_ch     = rep_ch;
  assign stall_pc   = (cmd_valid && !cmd_ready)
                    || (sync_pend && !sync_cpl);
  assign npu_arg0   = a0_q;
  assign npu_arg1   = a1_q;

  // per-channel next state and status decode
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]      = st_q[i];
      npu_start[i] = (st_q[i] == CH_START);
      busy[i]      = (st_q[i] != CH_IDLE);
      unique case (st_q[i])
        CH_IDLE:  if (pop && head_ch == CHW'(i)) st_d[i] = CH_START;
        CH_START: st_d[i] = CH_BUSY;
        CH_BUSY:  if (npu_done[i] || expire[i]) st_d[i] = CH_DONE;
        CH_DONE:  if (rep_valid && rep_ch == CHW'(i)) st_d[i] = CH_IDLE;
        default:  st_d[i] = CH_IDLE;
      endcase
    end
  end

  // command FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_ch[i]   <= '0;
        q_a0[i]   <= '0;
        q_a1[i]   <= '0;
        q_sync[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        q_ch[wr_ptr]   <= cmd_ch;
        q_a0[wr_ptr]   <= cmd_arg0;
        q_a1[wr_ptr]   <= cmd_arg1;
        q_sync[wr_ptr] <= cmd_sync;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  // channel state, operand latches and sync tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) st_q[i] <= CH_IDLE;
      a0_q      <= '0;
      a1_q      <= '0;
      ch_sync_q <= '0;
      sync_pend <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i] <= st_d[i];
        if (pop && head_ch == CHW'(i)) begin
          a0_q[i]      <= q_a0[rd_ptr];
          a1_q[i]      <= q_a1[rd_ptr];
          ch_sync_q[i] <= q_sync[rd_ptr];
        end
      end
      if (push && cmd_sync) sync_pend <= 1'b1;
      else if (sync_cpl)    sync_pend <= 1'b0;
    end
  end

`ifdef NPU_DISPATCH_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0]    wd_q [NUM_CH];
  logic [NUM_CH-1:0] stat_q;

  // expiry on the edge that would complete the last allowed BUSY cycle
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      expire[i] = (st_q[i] == CH_BUSY)
               && (wd_q[i] == WDW'(TIMEOUT_CYCLES - 1));
    end
  end

  // watchdog counters and timeout status capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) wd_q[i] <= '0;
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (st_q[i] == CH_START)     wd_q[i] <= '0;
        else if (st_q[i] == CH_BUSY) wd_q[i] <= wd_q[i] + 1'b1;
        if (st_q[i] == CH_BUSY && st_d[i] == CH_DONE)
          stat_q[i] <= !npu_done[i];
      end
    end
  end

  assign cpl_status = rep_valid && stat_q[rep_ch];
`else
  logic unused_tmo;

  assign expire     = '0;
  assign cpl_status = 1'b0;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_npu_dispatch.sv
// tb_npu_dispatch: directed stimulus for npu_dispatch with a completion
// scoreboard checked by an independent monitor.
module tb_npu_dispatch;

  localparam int XLEN   = 64;
  localparam int NUM_CH = 2;
  localparam int QD     = 4;
  localparam int TMO    = 16;
  localparam int CHW    = 1;

  logic                   clk;
  logic                   rst_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [CHW-1:0]         cmd_ch;
  logic [XLEN-1:0]        cmd_arg0;
  logic [XLEN-1:0]        cmd_arg1;
  logic                   cmd_sync;
  logic [NUM_CH-1:0]      npu_start;
  logic [NUM_CH*XLEN-1:0] npu_arg0;
  logic [NUM_CH*XLEN-1:0] npu_arg1;
  logic [NUM_CH-1:0]      npu_done;
  logic                   cpl_valid;
  logic [CHW-1:0]         cpl_ch;
  logic                   cpl_status;
  logic                   stall_pc;
  logic [NUM_CH-1:0]      busy;

  npu_dispatch #(
    .XLEN(XLEN), .NUM_CH(NUM_CH),
    .QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_arg0(cmd_arg0),
    .cmd_arg1(cmd_arg1), .cmd_sync(cmd_sync),
    .npu_start(npu_start), .npu_arg0(npu_arg0),
    .npu_arg1(npu_arg1), .npu_done(npu_done),
    .cpl_valid(cpl_valid), .cpl_ch(cpl_ch),
    .cpl_status(cpl_status), .stall_pc(stall_pc),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic           st;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t mk(int ch, logic st);
    exp_t e;
    e.ch = CHW'(ch);
    e.st = st;
    return e;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] a0_of(int ch);
    return npu_arg0[ch*XLEN +: XLEN];
  endfunction

  // completion monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && cpl_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL cpl_unexpected: got ch=%0d st=%0d expected none",
                 cpl_ch, cpl_status);
      end else begin
        e = sb.pop_front();
        if (cpl_ch !== e.ch || cpl_status !== e.st) begin
          errors++;
          $display("FAIL cpl: got ch=%0d st=%0d expected ch=%0d st=%0d",
                   cpl_ch, cpl_status, e.ch, e.st);
        end
      end
    end
  end

  task automatic push_cmd(int ch, logic [63:0] a0, logic [63:0] a1,
                          logic sy);
    chk("push_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_ch    = CHW'(ch);
    cmd_arg0  = a0;
    cmd_arg1  = a1;
    cmd_sync  = sy;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_sync  = 1'b0;
  endtask

  task automatic wait_start(int ch, logic [63:0] a0);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (npu_start[ch]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL start_ch%0d: got no pulse expected one in 20 cycles",
               ch);
    end
    chk("start_arg0", a0_of(ch), a0);
  endtask

  task automatic complete(int ch, int dly, logic [63:0] a0);
    repeat (dly) @(negedge clk);
    npu_done[ch] = 1'b1;
    sb.push_back(mk(ch, 1'b0));
    @(negedge clk);
    npu_done[ch] = 1'b0;
    chk("arg_held", a0_of(ch), a0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected one by 200000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_ch    = '0;
    cmd_arg0  = '0;
    cmd_arg1  = '0;
    cmd_sync  = 1'b0;
    npu_done  = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_start", npu_start, 0);
    chk("rst_arg0", npu_arg0[63:0], 0);
    chk("rst_cpl", cpl_valid, 0);
    chk("rst_stall", stall_pc, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single command on ch0
    push_cmd(0, 64'h11, 64'h22, 1'b0);
    wait_start(0, 64'h11);
    chk("t1_arg1", npu_arg1[63:0], 64'h22);
    chk("t1_busy", busy, 2'b01);
    @(negedge clk);
    chk("t1_pulse_len", npu_start, 0);
    complete(0, 4, 64'h11);
    chk("t1_idle", busy, 0);

    // fill queue behind a stuck ch1 job
    cmd_ch    = 1'b1;
    cmd_sync  = 1'b0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cmd_arg0 = 64'(k);
      cmd_arg1 = 64'(k);
      @(negedge clk);
    end
    cmd_arg0 = 64'd5;
    chk("t2_full_ready", cmd_ready, 0);
    chk("t2_full_stall", stall_pc, 1);
    chk("t2_busy", busy, 2'b10);
    @(negedge clk);
    chk("t2_hold_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    #1;
    chk("t2_stall_drop", stall_pc, 0);
    complete(1, 0, 64'd0);
    for (int k = 1; k < 5; k++) begin
      wait_start(1, 64'(k));
      complete(1, 1, 64'(k));
    end
    chk("t2_drained", busy, 0);

    // simultaneous completion on both channels
    push_cmd(0, 64'h30, 64'h30, 1'b0);
    push_cmd(1, 64'h31, 64'h31, 1'b0);
    repeat (3) @(negedge clk);
    npu_done = 2'b11;
    sb.push_back(mk(0, 1'b0));
    sb.push_back(mk(1, 1'b0));
    @(negedge clk);
    npu_done = 2'b00;
    chk("t3_both_busy", busy, 2'b11);
    chk("t3_first_ch", cpl_ch, 0);
    @(negedge clk);
    chk("t3_second_vld", cpl_valid, 1);
    chk("t3_second_ch", cpl_ch, 1);
    @(negedge clk);
    chk("t3_idle", busy, 0);

    // sync command stalls PC until its report
    chk("t4_pre_stall", stall_pc, 0);
    push_cmd(1, 64'h40, 64'h41, 1'b1);
    chk("t4_push_stall", stall_pc, 1);
    wait_start(1, 64'h40);
    repeat (10) begin
      @(negedge clk);
      chk("t4_busy_stall", stall_pc, 1);
    end
    npu_done[1] = 1'b1;
    sb.push_back(mk(1, 1'b0));
    @(negedge clk);
    npu_done[1] = 1'b0;
    chk("t4_report_vld", cpl_valid, 1);
    chk("t4_report_stall", stall_pc, 0);
    @(negedge clk);
    chk("t4_after_stall", stall_pc, 0);

`ifdef NPU_DISPATCH_WATCHDOG_EN
    // watchdog expiry, then done racing expiry
    begin
      int n;
      push_cmd(0, 64'h50, 64'h0, 1'b0);
      wait_start(0, 64'h50);
      sb.push_back(mk(0, 1'b1));
      @(negedge clk);
      n = 0;
      while (!cpl_valid && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("t5_wd_cycles", 64'(n), 16);
      @(negedge clk);
      push_cmd(0, 64'h51, 64'h0, 1'b0);
      wait_start(0, 64'h51);
      @(negedge clk);
      repeat (15) @(negedge clk);
      npu_done[0] = 1'b1;
      sb.push_back(mk(0, 1'b0));
      @(negedge clk);
      npu_done[0] = 1'b0;
      chk("t5_race_vld", cpl_valid, 1);
      @(negedge clk);
    end
`endif

    // reset while ch0 busy with two queued entries
    push_cmd(0, 64'h60, 64'h0, 1'b0);
    push_cmd(0, 64'h61, 64'h0, 1'b0);
    push_cmd(0, 64'h62, 64'h0, 1'b0);
    repeat (2) @(negedge clk);
    chk("t6_busy", busy, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", cmd_ready, 1);
    chk("t6_rst_start", npu_start, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_cpl", cpl_valid, 0);
    chk("t6_rst_stall", stall_pc, 0);
    chk("t6_rst_arg0", npu_arg0[63:0], 0);
    @(negedge clk);
    rst_n    = 1'b1;
    npu_done = 2'b01;
    repeat (3) begin
      @(negedge clk);
      chk("t6_late_cpl", cpl_valid, 0);
      chk("t6_late_busy", busy, 0);
    end
    npu_done = 2'b00;
    @(negedge clk);

    chk("sb_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/npu_dispatch.md
# npu_dispatch

Parametrised NPU command dispatcher between the osyrys64 core and up to NUM_CH accelerator channels, replacing the core's fixed two-line start/stall handshake. Accepts commands from decode via valid/ready, buffers them in an in-order queue, and issues each to its target channel with a one-cycle start pulse and held operands. Tracks one outstanding job per channel, reports completions with status, and drives the core's PC stall.

## Interface
- XLEN, 64, operand width
- NUM_CH, 2, accelerator channel count (≥1; CHW = max(1, $clog2(NUM_CH)))
- QUEUE_DEPTH, 4, command queue entries (power of two, ≥2)
- TIMEOUT_CYCLES, 1024, watchdog limit in BUSY cycles (only with watchdog compiled in)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  decode presents an NPU command
- cmd_ready  out  1  queue can accept; = !full
- cmd_ch  in  CHW  target channel
- cmd_arg0, cmd_arg1  in  XLEN  operands (rs1/rs2 data)
- cmd_sync  in  1  core must stall until this command completes
- npu_start  out  NUM_CH  one-cycle start pulse per channel
- npu_arg0, npu_arg1  out  NUM_CH*XLEN  per-channel operands, held from start until completion
- npu_done  in  NUM_CH  channel completion, sampled only in BUSY
- cpl_valid  out  1  one-cycle completion report
- cpl_ch  out  CHW  channel reported
- cpl_status  out  1  0 = ok, 1 = timeout
- stall_pc  out  1  hold core PC
- busy  out  NUM_CH  channel state ≠ IDLE

## Operation
- Queue: FIFO of {ch, arg0, arg1, sync}; push on cmd_valid && cmd_ready; pointers wrap modulo QUEUE_DEPTH; full/empty from count.
- Issue: head pops when its channel is IDLE; strictly in order (blocked head blocks everything behind it). At most one pop per cycle.
- Per-channel FSM: IDLE -> START on pop; START -> BUSY (npu_start[ch]=1 during START only); BUSY -> DONE on npu_done[ch] or watchdog expiry; DONE -> IDLE when reported.
- Report arbiter: among channels in DONE, lowest index reported; others stay in DONE (no loss).
- Args latched into channel registers on pop; stable until DONE->IDLE.
- stall_pc = (cmd_valid && !cmd_ready) || sync_pend. sync_pend set when a sync command is pushed; records its channel; cleared in the cycle its completion is reported (stall_pc low that same cycle).
- npu_done in IDLE, START or DONE ignored.

## Timing
- Reset values: cmd_ready=1, npu_start=0, npu_arg*=0, cpl_valid=0, cpl_ch=0, cpl_status=0, stall_pc=0 (combinational term still follows cmd_valid), busy=0; queue empty, all FSMs IDLE, sync_pend=0, watchdogs 0.
- Push at edge N → earliest pop at N+1, npu_start high cycle N+1..N+2 (START), BUSY from N+2.
- npu_done sampled high in BUSY at edge M → DONE at M, cpl_valid high M..M+1 if no contention, IDLE at M+1; channel may re-issue from that same edge.
- Full: cmd_ready low; simultaneous pop and push at full not allowed (ready is registered-state based). Empty: no pop.
- Simultaneous pop and report on the same channel: report wins; pop occurs next cycle.
- Reset mid-operation: all state cleared immediately; pending start pulses dropped, late npu_done ignored.

## Configuration
- NPU_DISPATCH_WATCHDOG_EN defined: per-channel counter, cleared on entering BUSY, increments each BUSY cycle; at TIMEOUT_CYCLES forces DONE with cpl_status=1. npu_done in the same cycle as expiry wins (status 0).
- Undefined: no counters; BUSY exits only on npu_done; cpl_status tied 0.

## Test plan
- Single cmd ch0, args 0x11/0x22, done 5 cycles after start -> one start pulse, npu_arg0[ch0]=0x11 held, cpl_valid with ch=0 status=0.
- Push 5 cmds to ch1 with QUEUE_DEPTH=4, done never for ch1 first job -> cmd_ready low after 4th queued entry, stall_pc high while cmd_valid held.
- ch0 and ch1 done same cycle -> cpl ch0 then ch1 on consecutive cycles, no loss.
- cmd_sync to ch1, done after 10 cycles -> stall_pc high from push until report cycle, low in report cycle.
- Watchdog on, TIMEOUT_CYCLES=16, no done -> cpl_status=1 after 16 BUSY cycles; done at cycle 16 -> status 0.
- rst_n low while ch0 BUSY and queue holds 2 entries -> all outputs at reset values; npu_done after release gives no cpl_valid.
